core_param: RTL and testbench
=============================

Name: core_param

Overview:
- Parametrised successor of the per-core item-memory accumulator in the HPU core array.
- Each exec looks up one item-memory word and signed-accumulates it (add or subtract, saturating) into a local accumulator.
- Results leave through the existing update/out_period shift chain to the neighbouring core.
- New in this generation: runtime-loadable item memory, configurable widths/depth, subtract mode, saturation, out-of-range detection, and a busy flag.

Parameters:
- DATA_W, 32, item-memory word width (signed).
- ACC_W, 32, accumulator width; must be >= DATA_W.
- DEPTH, 128, item-memory entries.
- ADDR_W, $clog2(DEPTH), exec/load address width; must be <= 32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- init  in  1  clear accumulator; pipelined, aligned with exec.
- load_en  in  1  item-memory write strobe.
- load_addr  in  ADDR_W  write address.
- load_data  in  DATA_W  write data.
- exec  in  1  issue one lookup-accumulate.
- exec_sub  in  1  with exec: 1 = subtract operand, 0 = add.
- exec_src_data  in  32  lookup address; low ADDR_W bits used, upper bits must be 0.
- out_period  in  1  shift acc_next into acc_right.
- update  in  1  select acc_left onto acc.
- acc_next  in  ACC_W  accumulator value from the next core in the chain.
- acc  out  ACC_W  combinational: update ? acc_left : acc_right.
- busy  out  1  any pipeline stage valid.
- err_oob  out  1  sticky out-of-range lookup flag.

Behaviour:
- Reset (rst=1 at a clock edge): acc_left=0, acc_right=0, all pipeline valids=0, err_oob=0, busy=0. Item memory is not reset.
- Reset mid-operation discards in-flight execs and inits; no accumulation from them occurs after reset.
- Pipeline is 3 stages and fully pipelined, accepting one exec per cycle:
  - S1, edge t+1: synchronous memory read; exec, exec_sub and init are registered.
  - S2, edge t+2: operand registered; sign-extended DATA_W to ACC_W and negated if exec_sub.
  - S3, edge t+3: accumulator update.
- An exec at cycle t is visible on acc_left from cycle t+3.
- S3 priority:
  - init_d3 and exec_d3: acc_left <= operand (clear-and-load).
  - init_d3 only: acc_left <= 0.
  - exec_d3 only: acc_left <= sat(acc_left + operand).
  - neither: hold.
- init at cycle t followed by exec at cycle t+1 accumulates into the cleared value. Ordering of init and exec is preserved.
- Arithmetic: compute at ACC_W+1 bits, then saturate to the signed ACC_W range.
  - Subtracting the most-negative DATA_W value yields +(2^(DATA_W-1)); this is representable when ACC_W > DATA_W and saturates otherwise.
- Out of range: if the address is >= DEPTH or any upper bit of exec_src_data is set, the operand is forced to 0 and err_oob sets at S3. err_oob is cleared only by rst.
- Load: write occurs at the edge where load_en=1. A same-cycle read of the same address returns the old data (read-first). Loads never stall exec.
- Output chain: acc_right <= acc_next when out_period, independent of exec/init. Both update and out_period may be high together.
- busy = exec_d1 | exec_d2 | exec_d3 | init_d1 | init_d2 | init_d3.

Optional Feature:
- Macro CORE_ITEM_INIT_EN.
- Defined: item memory initialised at elaboration to item_mem[i] = i, truncated to DATA_W, for all i < DEPTH.
- Undefined: no initial block; contents are X until written through the load port. The bench must load before exec.

Decomposition:
- Package core_pkg holds:
  - localparam defaults (DATA_W, ACC_W, DEPTH);
  - typedef enum logic {OP_ADD, OP_SUB} core_op_e;
  - a function sat_add(acc, operand) that is width-generic via parameterised ACC_W.
- One sub-module, core_item_mem: DEPTH x DATA_W synchronous-read, read-first RAM with a write port. It holds the CORE_ITEM_INIT_EN initial block.

Test Plan:
- CORE_ITEM_INIT_EN on: rst, init, then exec addr 3, 5, 7 on consecutive cycles -> acc_left = 3, 8, 15 at cycles t+3, t+4, t+5. With update=1, acc=15. busy falls 3 cycles after the last exec.
- Load addr 10 = -4 (DATA_W=32), then exec_sub addr 10 twice -> acc_left = 4, then 8.
- ACC_W=32: load addr 0 = 0x7FFFFFFF and addr 1 = 1. Sequence: init, exec 0, exec 1, exec 1 -> acc_left saturates at 0x7FFFFFFF and holds. Then exec_sub with -2 -> still 0x7FFFFFFF.
- init and exec addr 6 in the same cycle with prior acc_left=100 -> acc_left=6. Then init alone -> 0 three cycles later.
- exec_src_data=DEPTH (128), then 0x100 -> acc_left unchanged and err_oob=1 from t+3. After rst, err_oob=0.
- Chain: out_period=1 with acc_next=0xDEAD, update=0 -> acc=0xDEAD next cycle. rst asserted one cycle after an exec -> acc_left stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg: shared types, default sizes and arithmetic helpers for the
// core_param item-memory accumulator.
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ACC_W / DEFAULT_DEPTH  default sizes
//   MAX_ACC_W                                       widest supported ACC_W + 1
//   core_op_e                                       add / subtract selector
//   sat_add(acc, operand, acc_w)                    width-generic saturating add
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ACC_W  = 32;
  localparam int DEFAULT_DEPTH  = 128;

  // Containers for sat_add. Any ACC_W up to MAX_ACC_W-1 works, because the
  // operand is carried at ACC_W+1 bits.
  localparam int MAX_ACC_W = 64;

  typedef logic signed [MAX_ACC_W-1:0] acc_max_t;
  typedef logic signed [MAX_ACC_W:0]   acc_wide_t;

  typedef enum logic {OP_ADD, OP_SUB} core_op_e;

  // Adds two sign-extended values. The result is clamped to the signed range
  // of an acc_w-bit accumulator. The caller casts the result down to acc_w
  // bits. The callers pass a constant acc_w, so the unused upper part of the
  // adder is trimmed away.
  function automatic acc_max_t sat_add(input acc_max_t    acc,
                                       input acc_max_t    operand,
                                       input int unsigned acc_w);
    acc_wide_t sum;
    acc_wide_t one;
    acc_wide_t max_pos;
    acc_wide_t min_neg;
    one     = acc_wide_t'(1);
    sum     = acc_wide_t'(acc) + acc_wide_t'(operand);
    max_pos = (one <<< (acc_w - 1)) - one;
    min_neg = -(one <<< (acc_w - 1));
    if (sum > max_pos) begin
      return acc_max_t'(max_pos);
    end else if (sum < min_neg) begin
      return acc_max_t'(min_neg);
    end
    return acc_max_t'(sum);
  endfunction

endpackage

// File: rtl/core_item_mem.sv
// ---------------------------------------------------------------------------
// core_item_mem: DEPTH x DATA_W item memory.
// The read port is synchronous and read-first. The write port is separate.
//
// Ports:
//   clk      clock
//   wr_en    write strobe. Writes to addresses >= DEPTH are ignored.
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address. rd_data updates every clock.
//   rd_data  registered read data. On a same-address write in the same
//            cycle, this returns the old word.
//
// Build option:
//   CORE_ITEM_INIT_EN  When defined, the array is preloaded with mem[i] = i,
//                      truncated to DATA_W. When undefined, the contents are
//                      unknown until they are written.
// ---------------------------------------------------------------------------
module core_item_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef CORE_ITEM_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DATA_W'(i);
    end
  end
`endif

  // NOTE: the storage array has no reset. Clearing it would turn the RAM
  // into flops. Software must load entries before it looks them up.
  // NOTE: sequential state uses non-blocking assignments. This makes the read
  // below see the pre-write word, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en && (33'(wr_addr) < DEPTH_EXT)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/core_param.sv
// ---------------------------------------------------------------------------
// core_param: per-core item-memory accumulator with runtime-loadable memory.
//
// Each exec looks up one item-memory word. The word is sign-extended,
// optionally negated, and added with saturation into acc_left. acc_left
// reaches the chain through the update/out_period output mux.
//
// Pipeline (exec at cycle t):
//   edge t+1  memory read. exec, op, init and out-of-range are registered (d1).
//   edge t+2  operand is formed at ACC_W+1 bits (d2).
//   edge t+3  acc_left is updated. The d3 flags only track occupancy for busy.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   init           clear the accumulator. Travels in step with exec.
//   load_en/addr/data   item-memory write port. Never stalls exec.
//   exec, exec_sub      issue a lookup-accumulate. Subtract when exec_sub=1.
//   exec_src_data  32-bit lookup address. Values >= DEPTH are out of range.
//   out_period     shift acc_next into acc_right
//   update         acc = update ? acc_left : acc_right
//   acc_next       accumulator value from the next core in the chain
//   busy           any pipeline stage holds an exec or init
//   err_oob        sticky out-of-range flag. Only rst clears it.
//
// Build option:
//   CORE_ITEM_INIT_EN  preloads the item memory with mem[i] = i (see
//                      core_item_mem)
// ---------------------------------------------------------------------------
module core_param
  import core_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              exec,
  input  logic              exec_sub,
  input  logic [31:0]       exec_src_data,
  input  logic              out_period,
  input  logic              update,
  input  logic [ACC_W-1:0]  acc_next,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              err_oob
);

  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

  // Stage 1
  logic              exec_d1, init_d1, oob_d1;
  core_op_e          op_d1;
  logic [DATA_W-1:0] rd_data;
  // Stage 2
  logic              exec_d2, init_d2, oob_d2;
  logic signed [ACC_W:0] operand_d2;
  // Stage 3 occupancy
  logic              exec_d3, init_d3;
  // Accumulator and output chain
  logic signed [ACC_W-1:0] acc_left, acc_right;

  logic                    oob_s0;
  logic signed [ACC_W:0]   operand_ext;
  logic signed [ACC_W:0]   operand_s1;
  logic signed [ACC_W-1:0] acc_left_nx;

  // Any upper bit that is set also makes the 33-bit value >= DEPTH. A single
  // compare therefore covers both out-of-range cases.
  assign oob_s0 = ({1'b0, exec_src_data} >= DEPTH_EXT);

  core_item_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_item_mem (
    .clk     (clk),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (exec_src_data[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // The operand keeps one extra bit, so negating the most-negative item is
  // exact. The accumulate step saturates it if ACC_W cannot hold it.
  assign operand_ext = (ACC_W + 1)'($signed(rd_data));

  always_comb begin
    // NOTE: every variable written here gets a value first. This avoids
    // inferring a latch on paths that do not assign it.
    operand_s1 = operand_ext;
    if (oob_d1) begin
      operand_s1 = '0;
    end else if (op_d1 == OP_SUB) begin
      operand_s1 = -operand_ext;
    end
  end

  // Accumulate step. When init and exec arrive together, the accumulator is
  // cleared and loaded: the operand is added to zero and still saturated.
  always_comb begin
    acc_left_nx = acc_left;
    if (init_d2 && exec_d2) begin
      acc_left_nx = ACC_W'(sat_add('0, acc_max_t'(operand_d2), ACC_W));
    end else if (init_d2) begin
      acc_left_nx = '0;
    end else if (exec_d2) begin
      acc_left_nx = ACC_W'(sat_add(acc_max_t'(acc_left), acc_max_t'(operand_d2), ACC_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_d1    <= 1'b0;
      init_d1    <= 1'b0;
      oob_d1     <= 1'b0;
      op_d1      <= OP_ADD;
      exec_d2    <= 1'b0;
      init_d2    <= 1'b0;
      oob_d2     <= 1'b0;
      operand_d2 <= '0;
      exec_d3    <= 1'b0;
      init_d3    <= 1'b0;
      acc_left   <= '0;
      acc_right  <= '0;
      err_oob    <= 1'b0;
    end else begin
      exec_d1    <= exec;
      init_d1    <= init;
      oob_d1     <= exec & oob_s0;
      op_d1      <= exec_sub ? OP_SUB : OP_ADD;

      exec_d2    <= exec_d1;
      init_d2    <= init_d1;
      oob_d2     <= oob_d1;
      operand_d2 <= operand_s1;

      exec_d3    <= exec_d2;
      init_d3    <= init_d2;
      acc_left   <= acc_left_nx;

      if (exec_d2 && oob_d2) begin
        err_oob <= 1'b1;
      end
      if (out_period) begin
        acc_right <= $signed(acc_next);
      end
    end
  end

  assign acc  = update ? acc_left : acc_right;
  assign busy = exec_d1 | exec_d2 | exec_d3 | init_d1 | init_d2 | init_d3;

endmodule

// File: tb/tb_core_param.sv
// ---------------------------------------------------------------------------
// tb_core_param: directed, table-driven bench for core_param in its default
// configuration (DATA_W=32, ACC_W=32, DEPTH=128, item memory loaded through
// the load port).
// ---------------------------------------------------------------------------
module tb_core_param;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              exec;
  logic              exec_sub;
  logic [31:0]       exec_src_data;
  logic              out_period;
  logic              update;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  acc;
  logic              busy;
  logic              err_oob;

  int tests_run = 0;
  int tests_failed = 0;

  core_param #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .init          (init),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .exec          (exec),
    .exec_sub      (exec_sub),
    .exec_src_data (exec_src_data),
    .out_period    (out_period),
    .update        (update),
    .acc_next      (acc_next),
    .acc           (acc),
    .busy          (busy),
    .err_oob       (err_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        init;
    logic        exec;
    logic        sub;
    logic [31:0] addr;
    logic [31:0] exp_acc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init          = 1'b0;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    exec          = 1'b0;
    exec_sub      = 1'b0;
    exec_src_data = '0;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = ADDR_W'(addr);
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  task automatic add_vec(input string name, input logic i, input logic e, input logic s,
                         input logic [31:0] a, input logic [31:0] ea, input logic ee);
    vec_t v;
    v.name = name; v.init = i; v.exec = e; v.sub = s;
    v.addr = a; v.exp_acc = ea; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    out_period = 1'b0;
    update = 1'b1;
    acc_next = '0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    // ---- reset state ----
    check("reset_acc_left", 64'(acc), 64'h0);
    update = 1'b0;
    #1;
    check("reset_acc_right", 64'(acc), 64'h0);
    update = 1'b1;
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_err", 64'(err_oob), 64'h0);

    // ---- item memory contents ----
    for (int i = 0; i < 16; i++) load(i, 32'(i));
    load(10, 32'hFFFF_FFFC);  // -4
    load(20, 32'h7FFF_FFFF);
    load(21, 32'h0000_0001);
    load(22, 32'hFFFF_FFFE);  // -2
    load(23, 32'h8000_0000);  // most negative
    load(30, 32'd100);

    // ---- init then exec 3,5,7 back-to-back ----
    init = 1'b1; step(); init = 1'b0;
    exec = 1'b1; exec_src_data = 32'd3; step();
    exec_src_data = 32'd5; step();
    exec_src_data = 32'd7; step();
    idle_inputs();
    check("b2b_acc_3", 64'(acc), 64'd3);
    check("b2b_busy_mid", 64'(busy), 64'h1);
    step();
    check("b2b_acc_8", 64'(acc), 64'd8);
    step();
    check("b2b_acc_15", 64'(acc), 64'd15);
    check("b2b_busy_last", 64'(busy), 64'h1);
    step();
    check("b2b_busy_fall", 64'(busy), 64'h0);
    check("b2b_acc_hold", 64'(acc), 64'd15);

    // ---- single-operation vector table ----
    add_vec("init_only",        1, 0, 0, 32'd0,   32'h0000_0000, 0);
    add_vec("sub_neg4_a",       0, 1, 1, 32'd10,  32'h0000_0004, 0);
    add_vec("sub_neg4_b",       0, 1, 1, 32'd10,  32'h0000_0008, 0);
    add_vec("init_exec_100",    1, 1, 0, 32'd30,  32'h0000_0064, 0);
    add_vec("init_exec_6",      1, 1, 0, 32'd6,   32'h0000_0006, 0);
    add_vec("init_clear",       1, 0, 0, 32'd0,   32'h0000_0000, 0);
    add_vec("load_max",         0, 1, 0, 32'd20,  32'h7FFF_FFFF, 0);
    add_vec("sat_pos_a",        0, 1, 0, 32'd21,  32'h7FFF_FFFF, 0);
    add_vec("sat_pos_b",        0, 1, 0, 32'd21,  32'h7FFF_FFFF, 0);
    add_vec("sat_sub_neg2",     0, 1, 1, 32'd22,  32'h7FFF_FFFF, 0);
    add_vec("neg_minneg_sat",   1, 1, 1, 32'd23,  32'h7FFF_FFFF, 0);
    add_vec("load_minneg",      1, 1, 0, 32'd23,  32'h8000_0000, 0);
    add_vec("sat_neg",          0, 1, 1, 32'd21,  32'h8000_0000, 0);
    add_vec("from_minneg",      0, 1, 0, 32'd21,  32'h8000_0001, 0);
    add_vec("oob_depth",        0, 1, 0, 32'd128, 32'h8000_0001, 1);
    add_vec("oob_upper",        0, 1, 0, 32'h100, 32'h8000_0001, 1);
    add_vec("err_sticky",       0, 1, 0, 32'd5,   32'h8000_0006, 1);

    foreach (vecs[k]) begin
      init = vecs[k].init;
      exec = vecs[k].exec;
      exec_sub = vecs[k].sub;
      exec_src_data = vecs[k].addr;
      step();
      idle_inputs();
      step();
      step();
      check({vecs[k].name, "_acc"}, 64'(acc), 64'(vecs[k].exp_acc));
      check({vecs[k].name, "_err"}, 64'(err_oob), 64'(vecs[k].exp_err));
      step();
      check({vecs[k].name, "_busy"}, 64'(busy), 64'h0);
    end

    // ---- read-first: load and lookup of addr 7 in the same cycle ----
    init = 1'b1; exec = 1'b1; exec_src_data = 32'd7;
    load_en = 1'b1; load_addr = ADDR_W'(7); load_data = 32'd77;
    step();
    idle_inputs();
    step(); step();
    check("read_first_old", 64'(acc), 64'd7);
    init = 1'b1; exec = 1'b1; exec_src_data = 32'd7;
    step();
    idle_inputs();
    step(); step();
    check("read_first_new", 64'(acc), 64'd77);

    // ---- reset clears the sticky error and the accumulator ----
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_err_clear", 64'(err_oob), 64'h0);
    check("rst_acc_clear", 64'(acc), 64'h0);

    // ---- reset one cycle after an exec discards it ----
    exec = 1'b1; exec_src_data = 32'd5; step();
    idle_inputs();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rst_inflight_acc", 64'(acc), 64'h0);
    check("rst_inflight_busy", 64'(busy), 64'h0);

    // ---- output chain ----
    update = 1'b0; out_period = 1'b1; acc_next = 32'h0000_DEAD;
    step();
    check("chain_shift", 64'(acc), 64'h0000_DEAD);
    out_period = 1'b0; acc_next = 32'h0000_1234;
    step();
    check("chain_hold", 64'(acc), 64'h0000_DEAD);
    // update and out_period both high: the mux shows acc_left, and the shift
    // still happens underneath.
    update = 1'b1; out_period = 1'b1;
    step();
    check("chain_update_sel", 64'(acc), 64'h0);
    update = 1'b0; out_period = 1'b0;
    #1;
    check("chain_shift_both", 64'(acc), 64'h0000_1234);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
